vote_tally: RTL and testbench

- Parametrised, sequential successor to the combinational 3-input majority voter.
- Runs a voting session over N_VOTERS voters. Each voter may cast one yes/no ballot per session, and duplicate ballots are ignored.
- The session closes on all-voted, an explicit close request, or a timeout. The block then reports counts and an absolute-majority pass flag.
- Sits between per-voter request logic and a controller that consumes `done`/`pass`.

---
 rtl/vote_tally.sv | 126 ++++++++++++
 tb/tb_vote_tally.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vote_tally.sv
// vote_tally: session-based voting block for N_VOTERS voters.
// A session opens on start, accepts at most one yes/no ballot per voter,
// and closes when everyone has voted, on an explicit close request, or
// after TIMEOUT cycles in OPEN. Closing produces a one-cycle done pulse
// with a strict-absolute-majority pass flag. Counts, voted mask and pass
// then hold until the next session opens.
module vote_tally #(
    parameter int N_VOTERS = 5,
    parameter int TIMEOUT  = 16,
    localparam int CW      = $clog2(N_VOTERS + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                close,
    input  logic [N_VOTERS-1:0] cast,
    input  logic [N_VOTERS-1:0] choice,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [CW-1:0]       yes_cnt,
    output logic [CW-1:0]       no_cnt,
    output logic [N_VOTERS-1:0] voted
);

    // Timer only has to reach TIMEOUT-1; keep at least one bit when disabled.
    localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TLAST = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
    localparam logic [TW-1:0] T_LAST = TLAST[TW-1:0];
    // Voter count widened so that 2*yes can be compared without overflow.
    localparam logic [CW+1:0] N_EXT = (CW + 2)'(N_VOTERS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPEN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [TW-1:0]       timer;

    logic [N_VOTERS-1:0] accept;
    logic [CW-1:0]       yes_add;
    logic [CW-1:0]       no_add;
    logic [CW-1:0]       yes_next;
    logic [CW-1:0]       no_next;
    logic                all_voted;
    logic                timeout_hit;
    logic                close_hit;
    logic                pass_next;

    // Ballot acceptance, per-cycle tallies and the close decision for OPEN.
    always_comb begin
        accept  = '0;
        yes_add = '0;
        no_add  = '0;
        if (state == OPEN) begin
            // A voter already in the mask is a duplicate and is dropped.
            accept = cast & ~voted;
        end
        for (int i = 0; i < N_VOTERS; i++) begin
            yes_add = yes_add + CW'(accept[i] & choice[i]);
            no_add  = no_add + CW'(accept[i] & ~choice[i]);
        end
        yes_next    = yes_cnt + yes_add;
        no_next     = no_cnt + no_add;
        all_voted   = &(voted | accept);
        timeout_hit = (TIMEOUT != 0) && (timer == T_LAST);
        close_hit   = all_voted || close || timeout_hit;
        // Pass is judged on the final counts, including the closing cycle.
        pass_next   = {1'b0, yes_next, 1'b0} > N_EXT;
    end

    // Session FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            timer   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            yes_cnt <= '0;
            no_cnt  <= '0;
            voted   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    // Ballots arriving with start belong to no session.
                    if (start) begin
                        state   <= OPEN;
                        busy    <= 1'b1;
                        timer   <= '0;
                        pass    <= 1'b0;
                        yes_cnt <= '0;
                        no_cnt  <= '0;
                        voted   <= '0;
                    end
                end
                OPEN: begin
                    voted   <= voted | accept;
                    yes_cnt <= yes_next;
                    no_cnt  <= no_next;
                    timer   <= timer + TW'(1);
                    if (close_hit) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= pass_next;
                    end
                end
                DONE: begin
                    // Results stay put; only the pulse ends.
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vote_tally.sv
// Bench for vote_tally: a table of two-cycle sessions on a 5-voter block,
// hand-written sequences for reset, duplicates, timeout and mid-session
// reset, and a small 4-voter, timeout-disabled instance for ties.
module tb_vote_tally;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start, close;
    logic [4:0] cast, choice;
    logic       busy, done, pass;
    logic [2:0] yes_cnt, no_cnt;
    logic [4:0] voted;

    logic       start4, close4;
    logic [3:0] cast4, choice4;
    logic       busy4, done4, pass4;
    logic [2:0] yes4, no4;
    logic [3:0] voted4;

    vote_tally #(.N_VOTERS(5), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .start(start), .close(close),
        .cast(cast), .choice(choice), .busy(busy), .done(done),
        .pass(pass), .yes_cnt(yes_cnt), .no_cnt(no_cnt), .voted(voted)
    );

    vote_tally #(.N_VOTERS(4), .TIMEOUT(0)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .close(close4),
        .cast(cast4), .choice(choice4), .busy(busy4), .done(done4),
        .pass(pass4), .yes_cnt(yes4), .no_cnt(no4), .voted(voted4)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected session result packed as {pass, voted, yes, no}.
    logic [11:0] exp_q[$];
    logic [11:0] mon_e;

    function automatic logic [11:0] pack(input logic p, input logic [4:0] v,
                                         input logic [2:0] y, input logic [2:0] n);
        return {p, v, y, n};
    endfunction

    // Scoreboard: every done pulse consumes one expected result.
    always @(negedge clk) begin
        if (reset === 1'b0 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("done_pass", {31'd0, pass}, {31'd0, mon_e[11]});
                check("done_voted", {27'd0, voted}, {27'd0, mon_e[10:6]});
                check("done_yes", {29'd0, yes_cnt}, {29'd0, mon_e[5:3]});
                check("done_no", {29'd0, no_cnt}, {29'd0, mon_e[2:0]});
                check("done_busy", {31'd0, busy}, 32'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Inputs change on the falling edge; outputs are read on the next one.
    task automatic step(input logic st, input logic cl, input logic [4:0] ca, input logic [4:0] ch);
        start  = st;
        close  = cl;
        cast   = ca;
        choice = ch;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_done();
        int k = 0;
        while (exp_q.size() != 0 && k < 40) begin
            step(1'b0, 1'b0, 5'd0, 5'd0);
            k++;
        end
        if (exp_q.size() != 0) begin
            check("done_wait_expired", 32'd0, 32'd1);
            exp_q.delete();
        end
    endtask

    task automatic step4(input logic st, input logic cl, input logic [3:0] ca, input logic [3:0] ch);
        start4  = st;
        close4  = cl;
        cast4   = ca;
        choice4 = ch;
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic [4:0] c1, h1, c2, h2;
        logic       cl;
        logic [2:0] y, n;
        logic [4:0] v;
        logic       p;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int cyc;
        logic [11:0] e;

        // Two-cycle sessions: cycle1 ballots, cycle2 ballots (+optional close).
        vecs[0] = '{5'b00111, 5'b00011, 5'b11000, 5'b01000, 1'b0, 3'd3, 3'd2, 5'b11111, 1'b1};
        vecs[1] = '{5'b00000, 5'b00000, 5'b00011, 5'b00011, 1'b1, 3'd2, 3'd0, 5'b00011, 1'b0};
        vecs[2] = '{5'b11111, 5'b10101, 5'b11111, 5'b00000, 1'b0, 3'd3, 3'd2, 5'b11111, 1'b1};
        vecs[3] = '{5'b00001, 5'b00001, 5'b00001, 5'b00000, 1'b1, 3'd1, 3'd0, 5'b00001, 1'b0};
        vecs[4] = '{5'b01110, 5'b01110, 5'b10001, 5'b10000, 1'b0, 3'd4, 3'd1, 5'b11111, 1'b1};
        vecs[5] = '{5'b10010, 5'b00000, 5'b00101, 5'b00100, 1'b1, 3'd1, 3'd3, 5'b10111, 1'b0};
        vecs[6] = '{5'b00001, 5'b00000, 5'b00000, 5'b00000, 1'b0, 3'd0, 3'd1, 5'b00001, 1'b0};

        reset = 1'b1; start = 1'b0; close = 1'b0; cast = '0; choice = '0;
        start4 = 1'b0; close4 = 1'b0; cast4 = '0; choice4 = '0;
        @(negedge clk);

        // Reset from power-up state, held for two cycles.
        step(1'b1, 1'b1, 5'b11111, 5'b11111);
        step(1'b1, 1'b1, 5'b11111, 5'b11111);
        reset = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_pass", {31'd0, pass}, 32'd0);
        check("rst_yes", {29'd0, yes_cnt}, 32'd0);
        check("rst_no", {29'd0, no_cnt}, 32'd0);
        check("rst_voted", {27'd0, voted}, 32'd0);
        step(1'b0, 1'b1, 5'b11111, 5'b11111);
        step(1'b0, 1'b0, 5'b11111, 5'b11111);
        check("idle_cast_voted", {27'd0, voted}, 32'd0);
        check("idle_cast_busy", {31'd0, busy}, 32'd0);

        // Table-driven sessions.
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(pack(vecs[i].p, vecs[i].v, vecs[i].y, vecs[i].n));
            step(1'b1, 1'b0, 5'd0, 5'd0);
            check("vec_busy_open", {31'd0, busy}, 32'd1);
            step(1'b0, 1'b0, vecs[i].c1, vecs[i].h1);
            step(1'b0, vecs[i].cl, vecs[i].c2, vecs[i].h2);
            wait_done();
            // Results hold in IDLE and ballots there are ignored.
            step(1'b0, 1'b1, 5'b11111, 5'b11111);
            e = pack(vecs[i].p, vecs[i].v, vecs[i].y, vecs[i].n);
            check("hold_pass", {31'd0, pass}, {31'd0, e[11]});
            check("hold_voted", {27'd0, voted}, {27'd0, e[10:6]});
            check("hold_yes", {29'd0, yes_cnt}, {29'd0, e[5:3]});
            check("hold_no", {29'd0, no_cnt}, {29'd0, e[2:0]});
            check("hold_busy", {31'd0, busy}, 32'd0);
        end

        // Duplicate ballots from voter0, one no from voter1, then close.
        exp_q.push_back(pack(1'b0, 5'b00011, 3'd1, 3'd1));
        step(1'b1, 1'b0, 5'd0, 5'd0);
        step(1'b0, 1'b0, 5'b00001, 5'b00001);
        step(1'b0, 1'b0, 5'b00011, 5'b00001);
        step(1'b0, 1'b0, 5'b00001, 5'b00001);
        check("dup_yes_mid", {29'd0, yes_cnt}, 32'd1);
        step(1'b0, 1'b1, 5'd0, 5'd0);
        wait_done();

        // Timeout: done exactly 16 cycles after busy rises; start mid-session ignored.
        exp_q.push_back(pack(1'b1, 5'b00111, 3'd3, 3'd0));
        step(1'b1, 1'b0, 5'd0, 5'd0);
        check("to_busy_rise", {31'd0, busy}, 32'd1);
        step(1'b0, 1'b0, 5'b00111, 5'b00111);
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            step((cyc == 5) ? 1'b1 : 1'b0, 1'b0, 5'd0, 5'd0);
            cyc++;
        end
        check("to_cycles", cyc, 32'd16);
        step(1'b0, 1'b0, 5'd0, 5'd0);
        wait_done();

        // Reset in the middle of a session: no done, clean restart.
        step(1'b1, 1'b0, 5'd0, 5'd0);
        step(1'b0, 1'b0, 5'b00011, 5'b00011);
        check("mr_yes_before", {29'd0, yes_cnt}, 32'd2);
        reset = 1'b1;
        step(1'b0, 1'b0, 5'd0, 5'd0);
        reset = 1'b0;
        check("mr_busy", {31'd0, busy}, 32'd0);
        check("mr_done", {31'd0, done}, 32'd0);
        check("mr_yes", {29'd0, yes_cnt}, 32'd0);
        check("mr_voted", {27'd0, voted}, 32'd0);
        step(1'b0, 1'b0, 5'd0, 5'd0);
        step(1'b0, 1'b0, 5'd0, 5'd0);
        step(1'b0, 1'b0, 5'd0, 5'd0);
        check("mr_idle_busy", {31'd0, busy}, 32'd0);
        exp_q.push_back(pack(1'b0, 5'b00100, 3'd1, 3'd0));
        step(1'b1, 1'b0, 5'b11111, 5'b11111);
        check("clean_busy", {31'd0, busy}, 32'd1);
        check("clean_voted", {27'd0, voted}, 32'd0);
        check("clean_yes", {29'd0, yes_cnt}, 32'd0);
        step(1'b0, 1'b1, 5'b00100, 5'b00100);
        wait_done();

        // Four voters: a 2-2 tie fails.
        step4(1'b1, 1'b0, 4'd0, 4'd0);
        step4(1'b0, 1'b0, 4'b1111, 4'b0011);
        check("n4_tie_done", {31'd0, done4}, 32'd1);
        check("n4_tie_pass", {31'd0, pass4}, 32'd0);
        check("n4_tie_yes", {29'd0, yes4}, 32'd2);
        check("n4_tie_no", {29'd0, no4}, 32'd2);
        // Timeout disabled: session stays open until close.
        step4(1'b0, 1'b0, 4'd0, 4'd0);
        step4(1'b1, 1'b0, 4'd0, 4'd0);
        step4(1'b0, 1'b0, 4'b0001, 4'b0001);
        for (int i = 0; i < 20; i++) step4(1'b0, 1'b0, 4'd0, 4'd0);
        check("n4_still_busy", {31'd0, busy4}, 32'd1);
        check("n4_no_done", {31'd0, done4}, 32'd0);
        step4(1'b0, 1'b1, 4'd0, 4'd0);
        check("n4_close_done", {31'd0, done4}, 32'd1);
        check("n4_close_yes", {29'd0, yes4}, 32'd1);
        check("n4_close_pass", {31'd0, pass4}, 32'd0);
        // 3 of 4 passes.
        step4(1'b0, 1'b0, 4'd0, 4'd0);
        step4(1'b1, 1'b0, 4'd0, 4'd0);
        step4(1'b0, 1'b0, 4'b1111, 4'b0111);
        check("n4_maj_pass", {31'd0, pass4}, 32'd1);
        check("n4_maj_voted", {28'd0, voted4}, 32'hf);

        // ---------------- report ----------------
        step(1'b0, 1'b0, 5'd0, 5'd0);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
